// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with configurable frame format,
// per-word error flags and a first-word-fall-through RX FIFO with RTS# flow control.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset (synchronous release expected)
//   rxd            serial input, asynchronous, idle high
//   rts_n          request-to-send, active low; registered from next fill level
//   rd_data        FIFO head data (0 while empty)
//   rd_frame_err   head word saw a 0 in a stop bit
//   rd_parity_err  head word failed parity (always 0 when PARITY_MODE=0)
//   rd_valid       FIFO non-empty
//   rd_ready       pop request; head is popped when rd_valid && rd_ready
//   fifo_count     current fill level
//   overrun        sticky: a received word was dropped because the FIFO was full
//   overrun_clr    clears overrun (a same-cycle set wins)
//   break_det      (UART_RX_BREAK_DETECT_EN only) one-clock pulse on break entry
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN. When defined, an all-zero frame
// (data, parity and stop samples) is treated as a line break: nothing is pushed and
// the receiver waits for the line to return high.

module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ   = 12_000_000,
    parameter int BAUD_RATE_BPS = 115_200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rxd,
    output logic                          rts_n,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                          break_det
`endif
);

    localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE_BPS * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WW  = DATA_BITS + 2;

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_fifo: CLK_FREQ_HZ too low for BAUD_RATE_BPS*OVERSAMPLE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        S_BREAK
`endif
    } state_t;

    state_t state, state_next;

    logic                 rxd_meta, rxd_sync, rxd_prev;
    logic                 fall;
    logic [DW-1:0]        div_cnt;
    logic [OW-1:0]        os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 tick, mid_tick, bit_tick, sample, push;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc, perr, frame_err_now;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 any_one, brk_entry;
`endif

    logic [WW-1:0]        mem [FIFO_DEPTH];
    logic [WW-1:0]        head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_next;
    logic                 full, pop, push_ok;

    assign fall          = rxd_prev & ~rxd_sync;
    assign tick          = (div_cnt == DW'(DIV - 1));
    assign mid_tick      = tick && (os_cnt == OW'(OVERSAMPLE / 2 - 1));
    assign bit_tick      = tick && (os_cnt == OW'(OVERSAMPLE - 1));
    assign frame_err_now = ferr_acc | ~rxd_sync;

    // ---------------- receive FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        push       = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_entry  = 1'b0;
`endif
        case (state)
            S_IDLE:   if (fall) state_next = S_START;
            S_START: begin
                sample = mid_tick;
                if (mid_tick) state_next = rxd_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                sample = bit_tick;
                if (bit_tick && bit_cnt == BW'(DATA_BITS - 1))
                    state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                sample = bit_tick;
                if (bit_tick) state_next = S_STOP;
            end
            S_STOP: begin
                sample = bit_tick;
                if (bit_tick && bit_cnt == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (!any_one && !rxd_sync) begin
                        brk_entry  = 1'b1;
                        state_next = S_BREAK;
                    end else begin
                        push       = 1'b1;
                        state_next = S_IDLE;
                    end
`else
                    push       = 1'b1;
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            S_BREAK:  if (rxd_sync) state_next = S_IDLE;
`endif
            default:  state_next = S_IDLE;
        endcase
    end

    // ---------------- bit recovery datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
            div_cnt  <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
            perr     <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;

            // Divider and tick counter are held cleared in IDLE, so they restart
            // exactly at the start edge.
            if (state == S_IDLE || tick) div_cnt <= '0;
            else                         div_cnt <= div_cnt + DW'(1);

            if (state == S_IDLE || sample) os_cnt <= '0;
            else if (tick)                 os_cnt <= os_cnt + OW'(1);

            if (state_next != state) bit_cnt <= '0;
            else if (sample)         bit_cnt <= bit_cnt + BW'(1);

            if (state == S_DATA && sample)
                shreg <= {rxd_sync, shreg[DATA_BITS-1:1]};

            if (state == S_START)
                ferr_acc <= 1'b0;
            else if (state == S_STOP && sample && !rxd_sync)
                ferr_acc <= 1'b1;

            if (state == S_START)
                perr <= 1'b0;
            else if (state == S_PARITY && sample)
                perr <= ((^shreg) ^ rxd_sync) != (PARITY_MODE == 1);
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            any_one   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= brk_entry;
            if (state == S_START)
                any_one <= 1'b0;
            else if (sample && (state == S_DATA || state == S_PARITY || state == S_STOP))
                any_one <= any_one | rxd_sync;
        end
    end
`endif

    // ---------------- RX FIFO ----------------
    assign full     = (count == CW'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push && (!full || pop);

    always_comb begin
        count_next = count;
        if (push_ok && !pop)      count_next = count + CW'(1);
        else if (!push_ok && pop) count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {perr, frame_err_now, shreg};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rts_n   <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            rts_n <= (count_next >= CW'(RTS_THRESHOLD));
            if (push && full && !pop) overrun <= 1'b1;
            else if (overrun_clr)     overrun <= 1'b0;
        end
    end

    assign head          = mem[rd_ptr];
    assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_frame_err  = rd_valid & head[DATA_BITS];
    assign rd_parity_err = rd_valid & head[DATA_BITS+1];
    assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       rxd_a, rxd_b, rd_ready_a, rd_ready_b, clr_a, clr_b;
    logic       rts_n_a, rts_n_b, ferr_a, ferr_b, perr_a, perr_b;
    logic       valid_a, valid_b, ovr_a, ovr_b;
    logic [7:0] data_a, data_b;
    logic [4:0] count_a;
    logic [2:0] count_b;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       brk_a, brk_b;
    int         brk_cnt_a = 0;
    always @(negedge clk) if (brk_a) brk_cnt_a++;
`endif

    int errors = 0;
    int checks = 0;

    // 8N1, depth 16
    uart_rx_fifo #(
        .CLK_FREQ_HZ(12_000_000), .BAUD_RATE_BPS(750_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .resetn(resetn), .rxd(rxd_a), .rts_n(rts_n_a),
        .rd_data(data_a), .rd_frame_err(ferr_a), .rd_parity_err(perr_a),
        .rd_valid(valid_a), .rd_ready(rd_ready_a), .fifo_count(count_a),
        .overrun(ovr_a), .overrun_clr(clr_a)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_a)
`endif
    );

    // 8E2, depth 4, threshold 3
    uart_rx_fifo #(
        .CLK_FREQ_HZ(12_000_000), .BAUD_RATE_BPS(750_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4),
        .RTS_THRESHOLD(3)
    ) dut_b (
        .clk(clk), .resetn(resetn), .rxd(rxd_b), .rts_n(rts_n_b),
        .rd_data(data_b), .rd_frame_err(ferr_b), .rd_parity_err(perr_b),
        .rd_valid(valid_b), .rd_ready(rd_ready_b), .fifo_count(count_b),
        .overrun(ovr_b), .overrun_clr(clr_b)
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int nclk);
        if (sel) rxd_b = v;
        else     rxd_a = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_head(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit);
        drive(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
        if (has_par) drive(sel, pbit, 16);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit,
                        input int nstop, input logic [1:0] stops);
        send_head(sel, d, has_par, pbit);
        for (int i = 0; i < nstop; i++) drive(sel, stops[i], 16);
        drive(sel, 1'b1, 32);
    endtask

    task automatic pop(input bit sel);
        if (sel) rd_ready_b = 1'b1;
        else     rd_ready_a = 1'b1;
        @(negedge clk);
        rd_ready_a = 1'b0;
        rd_ready_b = 1'b0;
    endtask

    task automatic pulse_clr(input bit sel);
        if (sel) clr_b = 1'b1;
        else     clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } word_t;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [5];
        word_t q[$];
        word_t w;
        logic  ovr_m;
        int    waited;
        int    n;
`ifdef UART_RX_BREAK_DETECT_EN
        int    brk_before;
`endif

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
`ifdef UART_RX_BREAK_DETECT_EN
        tbl[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
`else
        tbl[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
`endif

        resetn = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1;
        rd_ready_a = 1'b0; rd_ready_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("reset rts_n", 32'(rts_n_a), 32'd1);
        chk("reset rd_valid", 32'(valid_a), 32'd0);
        chk("reset overrun", 32'(ovr_a), 32'd0);
        chk("reset rd_data", 32'(data_a), 32'd0);
        chk("reset count", 32'(count_a), 32'd0);
        resetn = 1'b1;
        waited = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            waited++;
            if (!rts_n_a) break;
        end
        chk("rts_n after release", 32'(rts_n_a), 32'd0);
        repeat (8) @(negedge clk);

        // 0xA5 with push latency measured from the start of the stop bit
        send_head(1'b0, 8'hA5, 1'b0, 1'b0);
        rxd_a = 1'b1;
        waited = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            waited++;
            if (valid_a) break;
        end
        chk("A5 rd_valid", 32'(valid_a), 32'd1);
        chk("A5 latency ok", 32'(waited <= 12), 32'd1);
        repeat (48 - waited) @(negedge clk);
        chk("A5 data", 32'(data_a), 32'hA5);
        chk("A5 ferr", 32'(ferr_a), 32'd0);
        chk("A5 perr", 32'(perr_a), 32'd0);
        pop(1'b0);
        chk("A5 popped valid", 32'(valid_a), 32'd0);
        chk("A5 popped count", 32'(count_a), 32'd0);

        // False start: 4 clk low pulse
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 40);
        chk("false start count", 32'(count_a), 32'd0);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        chk("after false start valid", 32'(valid_a), 32'd1);
        chk("after false start data", 32'(data_a), 32'h3C);
        pop(1'b0);

        // Table of single frames on the 8N1 receiver
        for (int i = 0; i < 5; i++) begin
`ifdef UART_RX_BREAK_DETECT_EN
            brk_before = brk_cnt_a;
`endif
            send(1'b0, tbl[i].data, 1'b0, 1'b0, 1, {1'b1, tbl[i].stop});
            chk($sformatf("tbl%0d valid", i), 32'(valid_a), 32'(tbl[i].exp_push));
            if (tbl[i].exp_push) begin
                chk($sformatf("tbl%0d data", i), 32'(data_a), 32'(tbl[i].exp_data));
                chk($sformatf("tbl%0d ferr", i), 32'(ferr_a), 32'(tbl[i].exp_ferr));
                chk($sformatf("tbl%0d perr", i), 32'(perr_a), 32'd0);
                pop(1'b0);
            end
`ifdef UART_RX_BREAK_DETECT_EN
            chk($sformatf("tbl%0d break pulses", i), 32'(brk_cnt_a - brk_before),
                32'(!tbl[i].exp_push));
`endif
            chk($sformatf("tbl%0d count after", i), 32'(count_a), 32'd0);
        end

        // Reset in the middle of a frame drops the partial frame and FIFO contents
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1, 2'b11);
        chk("pre-reset count", 32'(count_a), 32'd1);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 24);
        resetn = 1'b0;
        rxd_a = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        chk("mid-frame reset count", 32'(count_a), 32'd0);
        chk("mid-frame reset data", 32'(data_a), 32'd0);
        send(1'b0, 8'h96, 1'b0, 1'b0, 1, 2'b11);
        chk("post-reset data", 32'(data_a), 32'h96);
        chk("post-reset count", 32'(count_a), 32'd1);
        pop(1'b0);

        // Even parity on 0x01
        send(1'b1, 8'h01, 1'b1, 1'b0, 2, 2'b11);
        chk("parity bad perr", 32'(perr_b), 32'd1);
        chk("parity bad data", 32'(data_b), 32'h01);
        pop(1'b1);
        send(1'b1, 8'h01, 1'b1, 1'b1, 2, 2'b11);
        chk("parity good perr", 32'(perr_b), 32'd0);
        chk("parity good ferr", 32'(ferr_b), 32'd0);
        pop(1'b1);
        send(1'b1, 8'h81, 1'b1, 1'b0, 2, 2'b01);
        chk("second stop low ferr", 32'(ferr_b), 32'd1);
        chk("second stop low perr", 32'(perr_b), 32'd0);
        pop(1'b1);

        // Fill depth-4 FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'((i + 1) * 8'h11);
            send(1'b1, d, 1'b1, ^d, 2, 2'b11);
            chk($sformatf("fill%0d count", i), 32'(count_b), 32'((i + 1 > 4) ? 4 : i + 1));
            chk($sformatf("fill%0d rts_n", i), 32'(rts_n_b), 32'(i + 1 >= 3));
            chk($sformatf("fill%0d overrun", i), 32'(ovr_b), 32'(i == 4));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d data", i), 32'(data_b), 32'((i + 1) * 8'h11));
            pop(1'b1);
        end
        chk("drained valid", 32'(valid_b), 32'd0);
        chk("drained rts_n", 32'(rts_n_b), 32'd0);
        pop(1'b1);
        chk("pop empty count", 32'(count_b), 32'd0);
        chk("overrun sticky", 32'(ovr_b), 32'd1);
        pulse_clr(1'b1);
        chk("overrun cleared", 32'(ovr_b), 32'd0);

        // Random frames against a queue model of the FIFO
        ovr_m = 1'b0;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                logic [7:0] d;
                logic       flip, pb;
                logic [1:0] st;
                bit         is_break;
                d    = 8'($urandom_range(0, 255));
                flip = ($urandom_range(0, 3) == 0);
                st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                pb   = 1'($countones(d) % 2) ^ flip;
                is_break = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                is_break = (d == 8'h00) && !pb && (st == 2'b00);
`endif
                if (!is_break) begin
                    if (q.size() < 4) q.push_back('{d, st != 2'b11, flip});
                    else              ovr_m = 1'b1;
                end
                send(1'b1, d, 1'b1, pb, 2, st);
            end
            chk($sformatf("rnd%0d count", r), 32'(count_b), 32'(q.size()));
            chk($sformatf("rnd%0d overrun", r), 32'(ovr_b), 32'(ovr_m));
            chk($sformatf("rnd%0d rts_n", r), 32'(rts_n_b), 32'(q.size() >= 3));
            while (q.size() > 0) begin
                w = q.pop_front();
                chk($sformatf("rnd%0d data", r), 32'(data_b), 32'(w.data));
                chk($sformatf("rnd%0d ferr", r), 32'(ferr_b), 32'(w.ferr));
                chk($sformatf("rnd%0d perr", r), 32'(perr_b), 32'(w.perr));
                pop(1'b1);
            end
            chk($sformatf("rnd%0d empty", r), 32'(valid_b), 32'd0);
            pulse_clr(1'b1);
            ovr_m = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
